muldiv_unit: RTL and testbench

- Multi-cycle unsigned multiply/divide unit in the EX stage, beside the ALU.
- Consumes the same rs/rt operands the ALU receives and owns the architectural HI/LO registers.
- Replaces the single-cycle combinational divider path with a 32-iteration sequential engine.
- Drives a busy signal so the hazard unit can stall the pipeline.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 111 +++++++++++
 tb/tb_muldiv_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: op codes, FSM
// state encodings and the iteration count.
package muldiv_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_DIVU  = 2'd0,
        MD_MULTU = 2'd1,
        MD_MTHI  = 2'd2,
        MD_MTLO  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_DIV  = 2'd1,
        MD_MUL  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage (master) and the multiply/divide
// unit (slave).
interface muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cancel;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the sequential engine: restoring-division bit (MSB first)
// or shift-add multiply bit (LSB first), selected by mul_mode.
module muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic                mul_mode,
    input  logic [2*DATA_W-1:0] acc,
    input  logic [DATA_W-1:0]   a_sr,
    input  logic [DATA_W-1:0]   b_sr,
    output logic [2*DATA_W-1:0] acc_next,
    output logic [DATA_W-1:0]   a_next,
    output logic [DATA_W-1:0]   b_next
);
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W+1:0] trial;
    logic [DATA_W-1:0] addend;
    logic [DATA_W:0]   sum;
    logic              q_bit;

    always_comb begin
        // Division: remainder lives in acc[DATA_W:0], quotient bits shift into a_sr.
        rem_sh = {acc[DATA_W-1:0], a_sr[DATA_W-1]};
        trial  = {1'b0, rem_sh} - {2'b00, b_sr};
        q_bit  = ~trial[DATA_W+1];

        // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
        addend = b_sr[0] ? a_sr : '0;
        sum    = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, addend};

        if (mul_mode) begin
            acc_next = {sum, acc[DATA_W-1:1]};
            a_next   = a_sr;
            b_next   = b_sr >> 1;
        end else begin
            acc_next = {{(DATA_W-1){1'b0}}, (q_bit ? trial[DATA_W:0] : rem_sh)};
            a_next   = {a_sr[DATA_W-2:0], q_bit};
            b_next   = b_sr;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned MULTU/DIVU engine owning the HI/LO registers; busy
// stalls the pipeline for the 32 iterations, done pulses for one cycle after.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    md_state_e           state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [2*DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0]   a_reg, b_reg;
    logic [DATA_W-1:0]   hi_reg, lo_reg;
    logic                dz_reg, dz_saved_reg;

    logic [2*DATA_W-1:0] acc_next;
    logic [DATA_W-1:0]   a_next, b_next;
    logic                accept, last_iter, iterating;
    md_op_e              op_e;

    assign op_e      = md_op_e'(bus.op);
    assign iterating = (state_reg == MD_DIV) || (state_reg == MD_MUL);
    assign accept    = bus.start && !bus.cancel && !iterating;
    assign last_iter = (cnt_reg == CNT_W'(MD_ITER - 1));

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .mul_mode (state_reg == MD_MUL),
        .acc      (acc_reg),
        .a_sr     (a_reg),
        .b_sr     (b_reg),
        .acc_next (acc_next),
        .a_next   (a_next),
        .b_next   (b_next)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MD_IDLE, MD_DONE: begin
                state_next = MD_IDLE;
                if (accept && op_e == MD_DIVU)  state_next = MD_DIV;
                if (accept && op_e == MD_MULTU) state_next = MD_MUL;
            end
            MD_DIV, MD_MUL: begin
                if (bus.cancel)     state_next = MD_IDLE;
                else if (last_iter) state_next = MD_DONE;
            end
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= MD_IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            dz_reg       <= 1'b0;
            dz_saved_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                case (op_e)
                    MD_DIVU, MD_MULTU: begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.b;
                        acc_reg      <= '0;
                        cnt_reg      <= '0;
                        // Remember the flag so a flush can undo this start.
                        dz_saved_reg <= dz_reg;
                        if (op_e == MD_DIVU) dz_reg <= (bus.b == '0);
                    end
                    MD_MTHI: hi_reg <= bus.a;
                    MD_MTLO: lo_reg <= bus.a;
                    default: ;
                endcase
            end else if (iterating) begin
                if (bus.cancel) begin
                    dz_reg <= dz_saved_reg;
                end else begin
                    acc_reg <= acc_next;
                    a_reg   <= a_next;
                    b_reg   <= b_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        if (state_reg == MD_DIV) begin
                            hi_reg <= acc_next[DATA_W-1:0];
                            lo_reg <= a_next;
                        end else begin
                            hi_reg <= acc_next[2*DATA_W-1:DATA_W];
                            lo_reg <= acc_next[DATA_W-1:0];
                        end
                    end
                end
            end
        end
    end

    assign bus.busy     = iterating;
    assign bus.done     = (state_reg == MD_DONE);
    assign bus.div_zero = dz_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/div_zero
// and the done cycle; a negedge monitor pops and compares on every done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.DATA_W(32)) bus ();

    muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 lo=%h hi=%h, expected no done", bus.lo, bus.hi);
            end else begin
                e = sb.pop_front();
                check({e.name, "_lo"}, bus.lo, e.lo);
                check({e.name, "_hi"}, bus.hi, e.hi);
                check({e.name, "_dz"}, 32'(bus.div_zero), 32'(e.dz));
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input string name,
                         input logic [31:0] lo, input logic [31:0] hi, input logic dz);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        if (push) begin
            e.lo = lo; e.hi = hi; e.dz = dz; e.cyc = cyc + 32; e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done && sb.size() == 0) ok = 1'b1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_timeout: got busy=%b pending=%0d, expected idle", name, bus.busy, sb.size());
        end
    endtask

    initial begin
        int   n;
        int   e0;
        exp_t e;
        bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_dz", 32'(bus.div_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // DIVU 100/7 with busy duration
        issue(MD_DIVU, 32'd100, 32'd7, 1'b1, "divu_100_7", 32'd14, 32'd2, 1'b0);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("divu_busy_cycles", 32'(n), 32'd32);
        wait_idle("divu_100_7");

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu_max", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        wait_idle("multu_max");
        issue(MD_MULTU, 32'd3, 32'd5, 1'b1, "multu_3_5", 32'd15, 32'd0, 1'b0);
        wait_idle("multu_3_5");

        issue(MD_DIVU, 32'd5, 32'd0, 1'b1, "divu_5_0", 32'hFFFF_FFFF, 32'd5, 1'b1);
        wait_idle("divu_5_0");

        // Preload HI/LO, then flush a DIVU mid-flight
        issue(MD_MTHI, 32'hAAAA_AAAA, 32'd0, 1'b0, "", 32'd0, 32'd0, 1'b0);
        issue(MD_MTLO, 32'h5555_5555, 32'd0, 1'b0, "", 32'd0, 32'd0, 1'b0);
        check("mthi_hi", bus.hi, 32'hAAAA_AAAA);
        check("mtlo_lo", bus.lo, 32'h5555_5555);
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0, "", 32'd0, 32'd0, 1'b0);
        check("cancel_dz_during", 32'(bus.div_zero), 32'd0);
        repeat (9) @(negedge clk);
        check("cancel_busy_before", 32'(bus.busy), 32'd1);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy_after", 32'(bus.busy), 32'd0);
        repeat (40) @(negedge clk);
        check("cancel_hi", bus.hi, 32'hAAAA_AAAA);
        check("cancel_lo", bus.lo, 32'h5555_5555);
        check("cancel_dz_restored", 32'(bus.div_zero), 32'd1);

        // start together with cancel while idle: no effect
        @(negedge clk);
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MD_MTHI; bus.a = 32'h1234_5678;
        @(negedge clk);
        check("idle_cancel_mthi_hi", bus.hi, 32'hAAAA_AAAA);
        bus.op = MD_DIVU; bus.a = 32'd9; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        check("idle_cancel_divu_busy", 32'(bus.busy), 32'd0);

        issue(MD_DIVU, 32'd9, 32'd3, 1'b1, "divu_9_3", 32'd3, 32'd0, 1'b0);
        wait_idle("divu_9_3");

        // Back-to-back: start held through busy, accepted on the DONE cycle
        @(negedge clk);
        bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd2; bus.b = 32'd3;
        @(posedge clk);
        #1;
        e0 = cyc;
        e.lo = 32'd6; e.hi = 32'd0; e.dz = 1'b0; e.cyc = e0 + 32; e.name = "b2b_multu";
        sb.push_back(e);
        e.lo = 32'd8; e.hi = 32'd2; e.dz = 1'b0; e.cyc = e0 + 65; e.name = "b2b_divu";
        sb.push_back(e);
        @(negedge clk);
        bus.op = MD_DIVU; bus.a = 32'd50; bus.b = 32'd6;
        repeat (33) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_second_busy", 32'(bus.busy), 32'd1);
        wait_idle("b2b");

        // Asynchronous reset in the middle of a DIVU
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0, "", 32'd0, 32'd0, 1'b0);
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_hi", bus.hi, 32'd0);
        check("midreset_lo", bus.lo, 32'd0);
        check("midreset_dz", 32'(bus.div_zero), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        issue(MD_DIVU, 32'd7, 32'd2, 1'b1, "divu_7_2", 32'd3, 32'd1, 1'b0);
        wait_idle("divu_7_2");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
